nios_system_rx_pkt_writer: RTL and testbench
============================================

# nios_system_rx_pkt_writer

Packet-to-memory write stage that sits directly upstream of the `nios_system_main_memory` on-chip RAM. It accepts one receive packet per buffer descriptor on a 32-bit Avalon-ST sink (from the TSE receive path) and writes it into the RAM's single-port write interface. Each packet is written word by word, with byte-lane masking on the last beat. On completion it returns a status word holding the byte length and an error flag. It is the only write master on that RAM's s2 port.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: word-address width of the RAM.
- `DEPTH_WORDS`, 75000: RAM depth; addresses wrap from `DEPTH_WORDS-1` to 0.
- `MAX_PKT_WORDS`, 384: per-packet word limit (1536 bytes).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `buf_addr` in ADDR_WIDTH: start word address of the descriptor.
- `buf_valid` in 1, `buf_ready` out 1: descriptor handshake.
- `st_data` in 32: stream data; first symbol in [31:24].
- `st_valid` in 1, `st_ready` out 1: stream handshake.
- `st_sop`, `st_eop`, `st_error` in 1: start of packet, end of packet, and a MAC error flag valid on the eop beat.
- `st_empty` in 2: empty symbols on the eop beat.
- `mem_address` out ADDR_WIDTH, `mem_byteenable` out 4, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out 32, `mem_clken` out 1: RAM write port.
- `done_len` out 11: packet length in bytes.
- `done_err` out 1: packet error flag.
- `done_valid` out 1, `done_ready` in 1: status handshake.

## Operation
- FSM states: IDLE, WAIT_SOP, WRITE, DRAIN, DONE.
- IDLE: `buf_ready`=1. When `buf_valid` is high, latch `buf_addr` as the write pointer, clear the word count and error flag, then go to WAIT_SOP.
- WAIT_SOP: `st_ready`=1. Beats without `st_sop` are discarded.
  - An sop beat is written (word 0).
  - If that beat also has eop, go to DONE; otherwise go to WRITE.
- WRITE: `st_ready`=1. Every accepted beat is written to the pointer, then the pointer and word count increment.
  - An eop beat goes to DONE. OR `st_error` into the error flag.
  - An sop beat seen in WRITE is illegal: set the error flag, treat the beat as a new packet start, and keep writing at the current pointer.
  - If the word count equals `MAX_PKT_WORDS` and a non-eop beat arrives: the beat is not written, the error flag is set, and the FSM goes to DRAIN.
- DRAIN: `st_ready`=1, beats are dropped, no writes. The eop beat goes to DONE. `done_len` = `MAX_PKT_WORDS`*4.
- DONE: `done_valid`=1, with `done_len` and `done_err` held stable. On `done_ready`, go to IDLE.
- Byte order: stream byte k of a word goes to lane k. `mem_writedata` = {d[7:0], d[15:8], d[23:16], d[31:24]}.
- Byte enables: non-eop beats use 4'b1111. On eop beats, `st_empty` 0/1/2/3 gives 4'b1111 / 0111 / 0011 / 0001.
- Length: `done_len` = words_written*4 − empty, 11-bit.
- Pointer wrap: the pointer increments modulo `DEPTH_WORDS`.
- Fixed outputs: `mem_clken` is tied to 1. `mem_chipselect` equals `mem_write`.

## Timing
- Reset values: FSM in IDLE, `buf_ready`=1. All of these are 0: `st_ready`, `mem_write`, `mem_chipselect`, `mem_address`, `mem_byteenable`, `mem_writedata`, `done_valid`, `done_len`, `done_err`.
- All outputs are registered. `st_ready` and `buf_ready` are decoded from registered state only, with no combinational path from inputs.
- A beat accepted in cycle n produces its write at n+1: `mem_write`=1 for exactly one cycle, with address, data and byteenable valid in that cycle. The RAM has no waitrequest, so the writer sustains one write per cycle.
- `done_valid` rises in the cycle after the eop beat is accepted, which is the same cycle as the final write.
- Throughput: descriptor to first write takes at least 2 cycles. There are 2 idle cycles per packet (DONE→IDLE→WAIT_SOP), given immediate `done_ready` and `buf_valid`.
- Reset asserted mid-packet aborts the packet: no further writes and no status. Partially written RAM content is left as is.

## Structure
- Shared package `nios_system_rx_pkg`: FSM state enum, `MAX_PKT_WORDS`, and the empty→byteenable mapping function.
- One sub-module, `nios_system_rx_lane_pack`: the registered byte-swap plus byteenable generation stage.

## Test plan
- Single-beat packet: descriptor 0x00100, one beat 0xAABBCCDD with sop, eop and empty=1. Required: a write to 0x00100 with data 0x00CCBBAA (lanes 0–2 shown) and be=0111, then `done_len`=3, `done_err`=0.
- Descriptor 0x00000, 64-byte packet streamed back-to-back. Required: 16 consecutive-cycle writes to 0x00000–0x0000F, all be=1111, then `done_len`=64.
- Wrap: descriptor 74998, 4-word packet. Required: writes to 74998, 74999, 0, 1.
- Overflow: 400-word packet. Required: exactly 384 writes, remaining beats dropped, then `done_len`=1536, `done_err`=1.
- Stray beats: 2 non-sop beats followed by a 2-word packet with `st_error`=1 on eop. Required: no writes for the stray beats, 2 writes for the packet, then `done_err`=1.
- Reset asserted after the 3rd write of a 10-word packet. Required: no further writes, `done_valid` stays 0, FSM in IDLE with `buf_ready`=1.

Source files
------------

// File: rtl/nios_system_rx_pkg.sv
// Shared definitions for the receive packet writer: FSM encodings, the packet limit,
// the eop byte-enable mapping and the byte-length calculation.
package nios_system_rx_pkg;

   localparam int DEFAULT_MAX_PKT_WORDS = 384;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_SOP = 3'd1;
   localparam logic [2:0] S_WRITE    = 3'd2;
   localparam logic [2:0] S_DRAIN    = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   // Lanes are filled from lane 0 upward, so empty symbols always trim the top lanes.
   function automatic logic [3:0] empty_to_be(input logic eop, input logic [1:0] empty);
      logic [3:0] be;
      if (!eop) begin
         be = 4'b1111;
      end else begin
         case (empty)
            2'd0:    be = 4'b1111;
            2'd1:    be = 4'b0111;
            2'd2:    be = 4'b0011;
            default: be = 4'b0001;
         endcase
      end
      return be;
   endfunction

   function automatic logic [10:0] pkt_len(input logic [10:0] words, input logic [1:0] empty);
      logic [12:0] bytes;
      bytes = {words, 2'b00} - 13'(empty);
      return bytes[10:0];
   endfunction

endpackage

// File: rtl/nios_system_rx_lane_pack.sv
// Registered output stage: swaps stream byte order into RAM lanes and builds the
// byte enables for the write that follows each accepted beat.
module nios_system_rx_lane_pack
   import nios_system_rx_pkg::*;
#(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           data,
   input  logic                  eop,
   input  logic [1:0]            empty,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [3:0]            mem_byteenable,
   output logic [31:0]           mem_writedata
);

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= 4'b0000;
         mem_writedata  <= 32'h0;
      end else begin
         mem_write <= wr_en;
         if (wr_en) begin
            mem_address    <= addr;
            mem_byteenable <= empty_to_be(eop, empty);
            mem_writedata  <= {data[7:0], data[15:8], data[23:16], data[31:24]};
         end
      end
   end

endmodule

// File: rtl/nios_system_rx_pkt_writer.sv
// Writes one Avalon-ST receive packet per buffer descriptor into the on-chip RAM
// write port and reports its byte length and error flag on a status handshake.
module nios_system_rx_pkt_writer
   import nios_system_rx_pkg::*;
#(
   parameter int ADDR_WIDTH    = 17,
   parameter int DEPTH_WORDS   = 75000,
   parameter int MAX_PKT_WORDS = DEFAULT_MAX_PKT_WORDS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] buf_addr,
   input  logic                  buf_valid,
   output logic                  buf_ready,
   input  logic [31:0]           st_data,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic                  st_sop,
   input  logic                  st_eop,
   input  logic                  st_error,
   input  logic [1:0]            st_empty,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [3:0]            mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [31:0]           mem_writedata,
   output logic                  mem_clken,
   output logic [10:0]           done_len,
   output logic                  done_err,
   output logic                  done_valid,
   input  logic                  done_ready
);

   logic [2:0]            state, state_next;
   logic [ADDR_WIDTH-1:0] ptr, ptr_next, ptr_inc;
   logic [10:0]           word_count, count_next;
   logic                  err_next;
   logic [10:0]           len_next;
   logic                  wr_en;
   logic                  accept;

   assign buf_ready  = (state == S_IDLE);
   assign st_ready   = (state == S_WAIT_SOP) || (state == S_WRITE) || (state == S_DRAIN);
   assign done_valid = (state == S_DONE);
   assign accept     = st_valid && st_ready;
   assign ptr_inc    = (ptr == ADDR_WIDTH'(DEPTH_WORDS - 1)) ? '0 : ptr + 1'b1;

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      count_next = word_count;
      err_next   = done_err;
      len_next   = done_len;
      wr_en      = 1'b0;
      case (state)
         S_IDLE: begin
            if (buf_valid) begin
               ptr_next   = buf_addr;
               count_next = 11'd0;
               err_next   = 1'b0;
               state_next = S_WAIT_SOP;
            end
         end
         S_WAIT_SOP: begin
            if (accept && st_sop) begin
               wr_en      = 1'b1;
               ptr_next   = ptr_inc;
               count_next = 11'd1;
               if (st_eop) begin
                  err_next   = done_err | st_error;
                  len_next   = pkt_len(11'd1, st_empty);
                  state_next = S_DONE;
               end else begin
                  state_next = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (accept) begin
               // A full buffer never takes another word, eop or not, so the next buffer is safe.
               if (word_count == 11'(MAX_PKT_WORDS)) begin
                  err_next   = 1'b1;
                  len_next   = 11'(MAX_PKT_WORDS * 4);
                  state_next = st_eop ? S_DONE : S_DRAIN;
               end else begin
                  wr_en    = 1'b1;
                  ptr_next = ptr_inc;
                  if (st_sop) begin
                     err_next   = 1'b1;
                     count_next = 11'd1;
                  end else begin
                     count_next = word_count + 11'd1;
                  end
                  if (st_eop) begin
                     err_next   = err_next | st_error;
                     len_next   = pkt_len(count_next, st_empty);
                     state_next = S_DONE;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (accept && st_eop) begin
               err_next   = 1'b1;
               len_next   = 11'(MAX_PKT_WORDS * 4);
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (done_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         word_count <= 11'd0;
         done_err   <= 1'b0;
         done_len   <= 11'd0;
      end else begin
         state      <= state_next;
         ptr        <= ptr_next;
         word_count <= count_next;
         done_err   <= err_next;
         done_len   <= len_next;
      end
   end

   nios_system_rx_lane_pack #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_lane_pack (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (wr_en),
      .addr           (ptr),
      .data           (st_data),
      .eop            (st_eop),
      .empty          (st_empty),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_writedata  (mem_writedata)
   );

   assign mem_chipselect = mem_write;
   assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_nios_system_rx_pkt_writer.sv
// Directed bench for the receive packet writer: each task drives one scenario and
// compares RAM writes and status against hand-computed values.
module tb_nios_system_rx_pkt_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [16:0] buf_addr;
   logic        buf_valid;
   logic        buf_ready;
   logic [31:0] st_data;
   logic        st_valid;
   logic        st_ready;
   logic        st_sop;
   logic        st_eop;
   logic        st_error;
   logic [1:0]  st_empty;
   logic [16:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [10:0] done_len;
   logic        done_err;
   logic        done_valid;
   logic        done_ready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [16:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [3:0]  wb_q[$];
   int          wc_q[$];

   nios_system_rx_pkt_writer dut (
      .clk            (clk),
      .reset          (reset),
      .buf_addr       (buf_addr),
      .buf_valid      (buf_valid),
      .buf_ready      (buf_ready),
      .st_data        (st_data),
      .st_valid       (st_valid),
      .st_ready       (st_ready),
      .st_sop         (st_sop),
      .st_eop         (st_eop),
      .st_error       (st_error),
      .st_empty       (st_empty),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .done_len       (done_len),
      .done_err       (done_err),
      .done_valid     (done_valid),
      .done_ready     (done_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every RAM write is logged with the cycle it appeared in, for the tasks to inspect.
   always @(negedge clk) begin
      if (mem_write === 1'b1) begin
         wa_q.push_back(mem_address);
         wd_q.push_back(mem_writedata);
         wb_q.push_back(mem_byteenable);
         wc_q.push_back(cyc);
      end
   end

   task automatic clear_log;
      wa_q.delete();
      wd_q.delete();
      wb_q.delete();
      wc_q.delete();
   endtask

   task automatic send_desc(input logic [16:0] a);
      int n = 0;
      while (!buf_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!buf_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL desc_timeout buf_ready=%0b required 1", buf_ready);
      end
      buf_addr  = a;
      buf_valid = 1'b1;
      @(posedge clk); #1;
      buf_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                            input logic [1:0] empty, input logic err);
      int n = 0;
      st_data  = d;
      st_sop   = sop;
      st_eop   = eop;
      st_empty = empty;
      st_error = err;
      st_valid = 1'b1;
      while (!st_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!st_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL beat_timeout st_ready=%0b required 1", st_ready);
      end
      @(posedge clk); #1;
      st_valid = 1'b0;
   endtask

   task automatic wait_done(input logic [10:0] exp_len, input logic exp_err,
                            input string nm, output int dcyc);
      int n = 0;
      dcyc = -1;
      while (!done_valid && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (done_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_done_timeout done_valid=%0b required 1", nm, done_valid);
      end else begin
         dcyc = cyc;
         checks++;
         if (done_len !== exp_len) begin
            errors++;
            $display("[TB] FAIL %s_len got %0d required %0d", nm, done_len, exp_len);
         end
         checks++;
         if (done_err !== exp_err) begin
            errors++;
            $display("[TB] FAIL %s_err got %0b required %0b", nm, done_err, exp_err);
         end
         done_ready = 1'b1;
         @(posedge clk); #1;
         done_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (buf_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_buf_ready got %0b required 1", buf_ready); end
      checks++;
      if (st_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_st_ready got %0b required 0", st_ready); end
      checks++;
      if ({mem_write, mem_chipselect} !== 2'b00) begin errors++; $display("[TB] FAIL rst_write got %b required 00", {mem_write, mem_chipselect}); end
      checks++;
      if (mem_address !== 17'd0 || mem_byteenable !== 4'd0 || mem_writedata !== 32'd0) begin
         errors++;
         $display("[TB] FAIL rst_mem_bus got a=%h be=%b d=%h required zeros", mem_address, mem_byteenable, mem_writedata);
      end
      checks++;
      if ({done_valid, done_err, done_len} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL rst_done got v=%0b e=%0b l=%0d required 0", done_valid, done_err, done_len);
      end
      checks++;
      if (mem_clken !== 1'b1) begin errors++; $display("[TB] FAIL rst_clken got %0b required 1", mem_clken); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_beat;
      int dcyc;
      clear_log();
      send_desc(17'h00100);
      send_beat(32'hAABBCCDD, 1'b1, 1'b1, 2'd1, 1'b0);
      wait_done(11'd3, 1'b0, "single", dcyc);
      checks++;
      if (wa_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL single_count got %0d writes required 1", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 17'h00100) begin errors++; $display("[TB] FAIL single_addr got %h required 00100", wa_q[0]); end
         checks++;
         if ((wd_q[0] & 32'h00FFFFFF) !== 32'h00CCBBAA) begin errors++; $display("[TB] FAIL single_data got %h required xxCCBBAA", wd_q[0]); end
         checks++;
         if (wb_q[0] !== 4'b0111) begin errors++; $display("[TB] FAIL single_be got %b required 0111", wb_q[0]); end
         checks++;
         if (wc_q[0] != dcyc) begin errors++; $display("[TB] FAIL single_done_timing write cyc %0d done cyc %0d required equal", wc_q[0], dcyc); end
      end
   endtask

   task automatic test_back_to_back;
      int dcyc;
      clear_log();
      send_desc(17'h00000);
      for (int i = 0; i < 16; i++) begin
         send_beat(32'h01020304 + 32'(i) * 32'h04040404, i == 0, i == 15, 2'd0, 1'b0);
      end
      wait_done(11'd64, 1'b0, "b2b", dcyc);
      checks++;
      if (wa_q.size() != 16) begin
         errors++;
         $display("[TB] FAIL b2b_count got %0d writes required 16", wa_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (wa_q[i] !== 17'(i) || wb_q[i] !== 4'b1111 ||
                wd_q[i] !== 32'h04030201 + 32'(i) * 32'h04040404 || wc_q[i] != wc_q[0] + i) begin
               errors++;
               $display("[TB] FAIL b2b_word%0d got a=%h be=%b d=%h cyc+%0d required a=%h be=1111 d=%h cyc+%0d",
                        i, wa_q[i], wb_q[i], wd_q[i], wc_q[i] - wc_q[0], 17'(i),
                        32'h04030201 + 32'(i) * 32'h04040404, i);
            end
         end
      end
   endtask

   task automatic test_wrap;
      int dcyc;
      logic [16:0] exp_addr [4];
      exp_addr = '{17'd74998, 17'd74999, 17'd0, 17'd1};
      clear_log();
      send_desc(17'd74998);
      for (int i = 0; i < 4; i++) begin
         send_beat(32'hC0DE0000 + 32'(i), i == 0, i == 3, 2'd0, 1'b0);
      end
      wait_done(11'd16, 1'b0, "wrap", dcyc);
      checks++;
      if (wa_q.size() != 4) begin
         errors++;
         $display("[TB] FAIL wrap_count got %0d writes required 4", wa_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_q[i] !== exp_addr[i]) begin
               errors++;
               $display("[TB] FAIL wrap_addr%0d got %0d required %0d", i, wa_q[i], exp_addr[i]);
            end
         end
      end
   endtask

   task automatic test_overflow;
      int dcyc;
      clear_log();
      send_desc(17'h00200);
      for (int i = 0; i < 400; i++) begin
         send_beat(32'(i), i == 0, i == 399, 2'd0, 1'b0);
      end
      wait_done(11'd1536, 1'b1, "ovf", dcyc);
      checks++;
      if (wa_q.size() != 384) begin
         errors++;
         $display("[TB] FAIL ovf_count got %0d writes required 384", wa_q.size());
      end else begin
         checks++;
         if (wa_q[383] !== 17'h00200 + 17'd383) begin
            errors++;
            $display("[TB] FAIL ovf_last_addr got %h required %h", wa_q[383], 17'h00200 + 17'd383);
         end
      end
   endtask

   task automatic test_stray;
      int dcyc;
      clear_log();
      send_desc(17'h00300);
      send_beat(32'h11111111, 1'b0, 1'b0, 2'd0, 1'b0);
      send_beat(32'h22222222, 1'b0, 1'b1, 2'd0, 1'b1);
      send_beat(32'h33333333, 1'b1, 1'b0, 2'd0, 1'b0);
      send_beat(32'h44556677, 1'b0, 1'b1, 2'd2, 1'b1);
      wait_done(11'd6, 1'b1, "stray", dcyc);
      checks++;
      if (wa_q.size() != 2) begin
         errors++;
         $display("[TB] FAIL stray_count got %0d writes required 2", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 17'h00300 || wa_q[1] !== 17'h00301) begin
            errors++;
            $display("[TB] FAIL stray_addr got %h,%h required 00300,00301", wa_q[0], wa_q[1]);
         end
         checks++;
         if (wd_q[0] !== 32'h33333333 || wb_q[1] !== 4'b0011 || (wd_q[1] & 32'h0000FFFF) !== 32'h00005544) begin
            errors++;
            $display("[TB] FAIL stray_data got %h,%h be %b required 33333333,xxxx5544 be 0011", wd_q[0], wd_q[1], wb_q[1]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int seen = 0;
      clear_log();
      send_desc(17'h00400);
      for (int i = 0; i < 10 && seen < 3; i++) begin
         st_data  = 32'h10000000 + 32'(i);
         st_sop   = (i == 0);
         st_eop   = (i == 9);
         st_empty = 2'd0;
         st_error = 1'b0;
         st_valid = 1'b1;
         @(posedge clk); #1;
         if (mem_write === 1'b1) seen++;
      end
      checks++;
      if (seen != 3) begin errors++; $display("[TB] FAIL rmid_setup got %0d writes required 3", seen); end
      st_data = 32'h10000003;
      st_sop  = 1'b0;
      reset   = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            reset    = 1'b0;
            st_valid = 1'b0;
         end
         checks++;
         if (done_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done_c%0d got %0b required 0", c, done_valid); end
      end
      checks++;
      if (wa_q.size() != 3) begin errors++; $display("[TB] FAIL rmid_count got %0d writes required 3", wa_q.size()); end
      checks++;
      if (buf_ready !== 1'b1 || st_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rmid_idle got buf_ready=%0b st_ready=%0b required 1,0", buf_ready, st_ready);
      end
   endtask

   initial begin
      reset      = 1'b1;
      buf_addr   = '0;
      buf_valid  = 1'b0;
      st_data    = '0;
      st_valid   = 1'b0;
      st_sop     = 1'b0;
      st_eop     = 1'b0;
      st_error   = 1'b0;
      st_empty   = 2'd0;
      done_ready = 1'b0;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_wrap();
      test_overflow();
      test_stray();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
